// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_DATA   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic [3:0] OP_LD = 4'h8;
  localparam logic [3:0] OP_ST = 4'h9;

  localparam logic SEL_PC   = 1'b0;
  localparam logic SEL_REGA = 1'b1;

  // True for the opcodes that need a second (data) memory access.
  function automatic logic isMemOp(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/access_wait_timer.sv
// Counts wait cycles of one memory access and flags when the wait budget is used up.
module access_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over counting; the count saturates at the limit so it can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Wait count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences instruction fetch and data access over the shared memory address path.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mem_ack,
  input  logic [3:0] opcode,
  output logic       sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       rd_load,
  output logic       busy,
  output logic       timeout_err
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       waitClear;
  logic       waitEnable;
  logic       waitExpired;

  // Next-state and opcode latch; an ack always beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack)          state_d = ST_DECODE;
        else if (waitExpired) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        op_d = opcode;
        if (isMemOp(opcode)) state_d = ST_DATA;
        else                 state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_DATA: begin
        if (mem_ack)          state_d = run ? ST_FETCH : ST_IDLE;
        else if (waitExpired) state_d = ST_ERROR;
      end
      ST_ERROR: begin
        if (!run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched opcode registers; reset drops any in-flight access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign waitClear  = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                      ((state_d == ST_DATA)  && (state_q != ST_DATA));
  assign waitEnable = ((state_q == ST_FETCH) || (state_q == ST_DATA)) && !mem_ack;

  access_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (waitClear),
    .enable (waitEnable),
    .expired(waitExpired)
  );

  assign sel         = (state_q == ST_DATA) ? SEL_REGA : SEL_PC;
  assign mem_req     = (state_q == ST_FETCH) || (state_q == ST_DATA);
  assign mem_we      = (state_q == ST_DATA) && (op_q == OP_ST);
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_DATA);
  assign timeout_err = (state_q == ST_ERROR);

  assign ir_load = (state_q == ST_FETCH) && mem_ack;
  assign pc_inc  = (state_q == ST_FETCH) && mem_ack;
  assign rd_load = (state_q == ST_DATA) && mem_ack && (op_q == OP_LD);

endmodule
